// File: rtl/seven_segment_scan_pkg.sv
// ============================================================================
//  seven_segment_scan_pkg
//  Shared types for the seven-segment scan scheduler.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package seven_segment_scan_pkg;

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } scan_state_t;

endpackage : seven_segment_scan_pkg

`default_nettype wire

// File: rtl/seven_segment_scan_scheduler.sv
// ============================================================================
//  seven_segment_scan_scheduler
//  Multiplexed seven-segment driver: slot timer, blanking FSM, PWM and
//  double-buffered frame data, with registered outputs.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module seven_segment_scan_scheduler
    import seven_segment_scan_pkg::*;
#(
    parameter int clk_mhz         = 100,
    parameter int w_digit         = 8,
    parameter int digit_period_us = 125,
    parameter int blank_cycles    = 100,
    parameter int w_bright        = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic [w_digit*8-1:0]   frame_in,
    input  logic [w_digit-1:0]     digit_en,
    input  logic [w_bright-1:0]    brightness,
    output logic [7:0]             abcdefgh,
    output logic [w_digit-1:0]     digit,
    output logic                   frame_start
);

    localparam int SLOT_CYCLES = clk_mhz * digit_period_us;
    localparam int CW          = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam int SW          = (w_digit > 1) ? $clog2(w_digit) : 1;

    logic [SW-1:0]          slot_q,  slot_d;
    logic [CW-1:0]          cyc_q,   cyc_d;
    logic [w_bright-1:0]    phase_q;
    scan_state_t            state_q, state_d;

    logic [w_digit*8-1:0]   active_frame_q,  shadow_frame_q;
    logic [w_digit-1:0]     active_en_q,     shadow_en_q;
    logic [w_bright-1:0]    active_bright_q, shadow_bright_q;
    logic                   pending_q;

    logic [7:0]             abcdefgh_q;
    logic [w_digit-1:0]     digit_q;
    logic                   frame_start_q;

    logic                   slot_end;
    logic                   frame_first;
    logic                   lit;

    assign slot_end    = (cyc_q == CW'(SLOT_CYCLES - 1));
    assign frame_first = (slot_q == '0) && (cyc_q == '0);

    always_comb begin
        cyc_d   = cyc_q + CW'(1);
        slot_d  = slot_q;
        state_d = state_q;
        if (slot_end) begin
            cyc_d  = '0;
            slot_d = (slot_q == SW'(w_digit - 1)) ? '0 : slot_q + SW'(1);
        end
        case (state_q)
            ST_BLANK: if (cyc_q == CW'(blank_cycles - 1)) state_d = ST_ON;
            ST_ON:    if (slot_end)                        state_d = ST_BLANK;
            default:                                       state_d = ST_BLANK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q  <= '0;
            cyc_q   <= '0;
            phase_q <= '0;
            state_q <= ST_BLANK;
        end else begin
            slot_q  <= slot_d;
            cyc_q   <= cyc_d;
            phase_q <= phase_q + w_bright'(1);
            state_q <= state_d;
        end
    end

    // A load landing on the frame boundary still sets pending after the copy,
    // so its data waits for the following frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            active_frame_q  <= '0;
            active_en_q     <= '0;
            active_bright_q <= '0;
            shadow_frame_q  <= '0;
            shadow_en_q     <= '0;
            shadow_bright_q <= '0;
            pending_q       <= 1'b0;
        end else begin
            if (frame_first && pending_q) begin
                active_frame_q  <= shadow_frame_q;
                active_en_q     <= shadow_en_q;
                active_bright_q <= shadow_bright_q;
                pending_q       <= 1'b0;
            end
            if (load) begin
                shadow_frame_q  <= frame_in;
                shadow_en_q     <= digit_en;
                shadow_bright_q <= brightness;
                pending_q       <= 1'b1;
            end
        end
    end

    assign lit = (state_q == ST_ON) && (phase_q < active_bright_q) &&
                 active_en_q[slot_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            abcdefgh_q    <= '0;
            digit_q       <= '0;
            frame_start_q <= 1'b0;
        end else begin
            abcdefgh_q    <= lit ? active_frame_q[slot_q*8 +: 8] : 8'h00;
            digit_q       <= lit ? (w_digit'(1) << slot_q) : '0;
            frame_start_q <= frame_first;
        end
    end

    assign abcdefgh    = abcdefgh_q;
    assign digit       = digit_q;
    assign frame_start = frame_start_q;

endmodule : seven_segment_scan_scheduler

`default_nettype wire

// File: tb/tb_seven_segment_scan_scheduler.sv
// ============================================================================
//  tb_seven_segment_scan_scheduler
//  Directed and random scan checks against a frame-level display model.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_seven_segment_scan_scheduler;

    localparam int W_DIGIT  = 4;
    localparam int W_BRIGHT = 2;
    localparam int SLOT     = 16;
    localparam int BLANK    = 4;
    localparam int FRAME    = SLOT * W_DIGIT;
    localparam int PWM      = 1 << W_BRIGHT;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  load;
    logic [W_DIGIT*8-1:0]  frame_in;
    logic [W_DIGIT-1:0]    digit_en;
    logic [W_BRIGHT-1:0]   brightness;
    logic [7:0]            abcdefgh;
    logic [W_DIGIT-1:0]    digit;
    logic                  frame_start;

    seven_segment_scan_scheduler #(
        .clk_mhz         (1),
        .w_digit         (W_DIGIT),
        .digit_period_us (SLOT),
        .blank_cycles    (BLANK),
        .w_bright        (W_BRIGHT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .frame_in    (frame_in),
        .digit_en    (digit_en),
        .brightness  (brightness),
        .abcdefgh    (abcdefgh),
        .digit       (digit),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int u;          // cycle index since reset release, i.e. position in the scan
    int lit_count;

    // Display model: what the panel shows, and what is queued for the next frame.
    logic [31:0] m_act_f, m_sh_f;
    logic [3:0]  m_act_en, m_sh_en;
    logic [1:0]  m_act_b, m_sh_b;
    bit          m_pend;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_act_f = '0; m_act_en = '0; m_act_b = '0;
        m_sh_f  = '0; m_sh_en  = '0; m_sh_b  = '0;
        m_pend  = 1'b0;
    endtask

    // One clock: the outputs after the edge describe scan position u.
    task automatic step(input bit ld);
        int          sl, c, ph;
        bit          on;
        logic [7:0]  e_seg;
        logic [3:0]  e_dig;
        load = ld;
        @(posedge clk); #1;
        sl = (u / SLOT) % W_DIGIT;
        c  = u % SLOT;
        ph = u % PWM;
        on = (c >= BLANK) && (ph < int'(m_act_b)) && m_act_en[sl];
        e_dig = on ? 4'(1 << sl) : 4'h0;
        e_seg = on ? m_act_f[sl*8 +: 8] : 8'h00;
        if (on) lit_count++;
        check("digit", {4'h0, digit}, {4'h0, e_dig});
        check("segments", abcdefgh, e_seg);
        check("frame_start", {7'h0, frame_start}, {7'h0, (u % FRAME) == 0});
        if ((u % FRAME) == 0 && m_pend) begin
            m_act_f = m_sh_f; m_act_en = m_sh_en; m_act_b = m_sh_b;
            m_pend  = 1'b0;
        end
        if (ld) begin
            m_sh_f = frame_in; m_sh_en = digit_en; m_sh_b = brightness;
            m_pend = 1'b1;
        end
        u++;
        load = 1'b0;
    endtask

    task automatic run_to(input int target);
        while (u < target) step(1'b0);
    endtask

    task automatic seek(input int pos);
        while ((u % FRAME) != pos) step(1'b0);
    endtask

    task automatic reset_and_check();
        rst  = 1'b1;
        load = 1'b0;
        @(posedge clk); #1;
        check("rst_digit", {4'h0, digit}, 8'h00);
        check("rst_segments", abcdefgh, 8'h00);
        check("rst_frame_start", {7'h0, frame_start}, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        model_clear();
        rst = 1'b0;
        u   = 0;
    endtask

    initial begin
        rst = 1'b1; load = 1'b0;
        frame_in = '0; digit_en = '0; brightness = '0;
        lit_count = 0;
        model_clear();
        reset_and_check();

        // Steady scan, full brightness
        frame_in = 32'h3F065B4F; digit_en = 4'hF; brightness = 2'd3;
        seek(5); step(1'b1);
        run_to(3 * FRAME);

        // Digit 2 disabled
        digit_en = 4'b1011;
        seek(10); step(1'b1);
        run_to(u - (u % FRAME) + 2 * FRAME);

        // Brightness 0 then 1
        digit_en = 4'hF; brightness = 2'd0;
        seek(3); step(1'b1);
        run_to(u - (u % FRAME) + 2 * FRAME);
        brightness = 2'd1;
        seek(3); step(1'b1);
        seek(0); seek(1); seek(0);
        lit_count = 0;
        seek(1); seek(0);
        check("lit_cycles_b1", 8'(lit_count), 8'(W_DIGIT * (SLOT - BLANK) / PWM));

        // Load in slot 2, then a load exactly on the frame boundary
        brightness = 2'd3; frame_in = 32'h11223344;
        seek(2 * SLOT + 3); step(1'b1);
        frame_in = 32'hA5C3E781;
        seek(0); step(1'b1);
        run_to(u + 3 * FRAME);

        // Random loads, data, masks and brightness
        for (int i = 0; i < 8 * FRAME; i++) begin
            frame_in   = $urandom;
            digit_en   = 4'($urandom);
            brightness = 2'($urandom);
            step(($urandom_range(0, 31) == 0));
        end

        // Reset in slot 1 cycle 9 with a frame still pending
        frame_in = 32'h7F7F7F7F; digit_en = 4'hF; brightness = 2'd3;
        seek(7); step(1'b1);
        run_to(u - (u % FRAME) + 2 * FRAME);
        frame_in = 32'h01020304;
        seek(2); step(1'b1);
        seek(SLOT + 9);
        reset_and_check();
        run_to(2 * FRAME);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_seven_segment_scan_scheduler

`default_nettype wire

// File: doc/seven_segment_scan_scheduler.md
SEVEN_SEGMENT_SCAN_SCHEDULER -- requirements
Module: seven_segment_scan_scheduler

Interface
REQ-001 SHALL have parameter clk_mhz, default 100: system clock frequency in MHz.
REQ-002 SHALL have parameter w_digit, default 8: number of multiplexed digits.
REQ-003 SHALL have parameter digit_period_us, default 125: time slot per digit in microseconds; slot_cycles = clk_mhz * digit_period_us.
REQ-004 SHALL have parameter blank_cycles, default 100: anti-ghost blanking at the start of each slot; must be less than slot_cycles.
REQ-005 SHALL have parameter w_bright, default 4: brightness code width.
REQ-006 SHALL have port clk, input, 1 bit: the single clock.
REQ-007 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port load, input, 1 bit: one-cycle strobe that captures frame_in, digit_en and brightness.
REQ-009 SHALL have port frame_in, input, w_digit*8 bits: byte i holds the abcdefgh pattern for digit i.
REQ-010 SHALL have port digit_en, input, w_digit bits: per-digit enable mask.
REQ-011 SHALL have port brightness, input, w_bright bits: PWM duty code.
REQ-012 SHALL have port abcdefgh, output, 8 bits: active-high segments, registered.
REQ-013 SHALL have port digit, output, w_digit bits: one-hot-or-zero active-high digit select, registered.
REQ-014 SHALL have port frame_start, output, 1 bit: one-cycle pulse at the first cycle of slot 0.

Function
REQ-015 SHALL scan slots 0 to w_digit-1 cyclically; each slot SHALL last exactly slot_cycles clocks; slot w_digit-1 SHALL wrap to 0.
REQ-016 SHALL run a two-state FSM per slot.
- ST_BLANK: slot cycles 0 to blank_cycles-1; digit and abcdefgh are 0.
- ST_ON: remaining cycles; BLANK goes to ON at cycle blank_cycles; ON goes to BLANK at the slot wrap.
REQ-017 In ST_ON, a free-running w_bright-bit PWM phase counter SHALL be used.
- Digit i is driven (digit = 1<<i, abcdefgh = active byte i) only when phase < active brightness and active digit_en[i] = 1.
- Otherwise both outputs are 0.
- Brightness 0 means dark; the maximum code gives a (2^w_bright - 1)/2^w_bright duty.
REQ-018 Outputs SHALL be registered with exactly one cycle of latency from the internal state and counters.
REQ-019 SHALL double-buffer the display data.
- load captures the inputs into shadow registers and sets the pending flag.
- On the first cycle of slot 0, if pending is set, shadow is copied to active and pending is cleared.
REQ-020 When load coincides with the slot-0 boundary, active SHALL take the previous shadow contents, and the new data SHALL take effect at the next frame.
REQ-021 Multiple loads within one frame SHALL leave the last captured value in shadow; earlier loads are overwritten.
REQ-022 A disabled digit SHALL still consume its full slot, so frame timing is independent of digit_en.
REQ-023 frame_start SHALL be asserted in the same cycle that the active copy takes effect.
REQ-024 Inputs SHALL be sampled only when load = 1.

Reset
REQ-025 On rst, all of the following SHALL be cleared to 0: slot index, cycle counter, PWM phase, FSM (ST_BLANK), active and shadow registers, pending flag, abcdefgh, digit and frame_start.
REQ-026 The first cycle after rst deasserts SHALL be slot 0 cycle 0; frame_start SHALL pulse one cycle later, per the registered output latency.
REQ-027 rst asserted mid-slot SHALL abort the scan immediately and discard pending data.

Structure
REQ-028 Package seven_segment_scan_pkg SHALL hold the FSM state typedef (ST_BLANK, ST_ON).
REQ-029 The module SHALL be flat; slot timer, PWM and buffers are inline, and no sub-module is instantiated.

Verification
All scenarios use clk_mhz=1, digit_period_us=16, blank_cycles=4, w_digit=4, w_bright=2.
REQ-030 Steady scan
- Stimulus: load frame 0x3F_06_5B_4F, digit_en=4'hF, brightness=3.
- Response: each 16-cycle slot shows 4 cycles of blank, then a 3-of-4 duty of the correct byte with digit 1<<i; frame_start recurs every 64 cycles.
REQ-031 Disabled digit
- Stimulus: digit_en=4'b1011.
- Response: slot 2 outputs stay 0 for all 16 cycles; slot 3 starts at cycle 48 of the frame.
REQ-032 Brightness limits
- Stimulus: brightness=0, then brightness=1.
- Response: brightness 0 gives no nonzero output; brightness 1 gives exactly 3 lit cycles per slot.
REQ-033 Load timing
- Stimulus: load at slot 2, then load in the frame_start cycle.
- Response: the slot-2 load appears from the next frame; the boundary load is deferred one further frame.
REQ-034 Reset mid-slot
- Stimulus: rst at slot 1 cycle 9.
- Response: outputs are 0 the next cycle; after release, scanning restarts at slot 0 and the pending frame is discarded.
